// File: rtl/rdoq_pkg.sv
// Shared definitions for the RDOQ scan sequencer: FSM state type and default widths.
package rdoq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_UPD  = 3'd2,
        ST_WAIT = 3'd3,
        ST_ERR  = 3'd4
    } seq_state_t;

    localparam int unsigned CG_LOG2          = 4;
    localparam int unsigned SCAN_W_DEF       = 10;
    localparam int unsigned GR_WIDTH_DEF     = 3;
    localparam int unsigned LVL_W_DEF        = 16;
    localparam int unsigned DONE_TIMEOUT_DEF = 4;
    localparam int unsigned CSM_POS_W        = 16;

endpackage

// File: rtl/rdoq_scan_sequencer_if.sv
// Level-selector and context-manager handshakes of the RDOQ scan sequencer.
interface rdoq_scan_sequencer_if #(
    parameter int unsigned SCAN_W   = rdoq_pkg::SCAN_W_DEF,
    parameter int unsigned GR_WIDTH = rdoq_pkg::GR_WIDTH_DEF,
    parameter int unsigned LVL_W    = rdoq_pkg::LVL_W_DEF
);
    import rdoq_pkg::*;

    logic                 lvl_req;
    logic [SCAN_W-1:0]    lvl_pos;
    logic                 lvl_valid;
    logic [LVL_W-1:0]     lvl_value;

    logic                 csm_start;
    logic [LVL_W-1:0]     csm_level;
    logic [CSM_POS_W-1:0] csm_scan_pos;
    logic                 csm_cg_boundary;
    logic [GR_WIDTH-1:0]  csm_init_gr;
    logic                 csm_done;

    modport master (
        output lvl_req, lvl_pos,
        input  lvl_valid, lvl_value,
        output csm_start, csm_level, csm_scan_pos, csm_cg_boundary, csm_init_gr,
        input  csm_done
    );

    modport slave (
        input  lvl_req, lvl_pos,
        output lvl_valid, lvl_value,
        input  csm_start, csm_level, csm_scan_pos, csm_cg_boundary, csm_init_gr,
        output csm_done
    );

endinterface

// File: rtl/rdoq_done_watchdog.sv
// Loadable down-counter; expired is high while the count sits at zero.
module rdoq_done_watchdog #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);
    import rdoq_pkg::*;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/rdoq_scan_sequencer.sv
// Walks the RDOQ scan from last_pos down to 0: fetch level, pulse the context
// manager, wait for its done, then advance.
module rdoq_scan_sequencer #(
    parameter int unsigned SCAN_W       = rdoq_pkg::SCAN_W_DEF,
    parameter int unsigned CG_LOG2      = rdoq_pkg::CG_LOG2,
    parameter int unsigned GR_WIDTH     = rdoq_pkg::GR_WIDTH_DEF,
    parameter int unsigned LVL_W        = rdoq_pkg::LVL_W_DEF,
    parameter int unsigned DONE_TIMEOUT = rdoq_pkg::DONE_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   blk_start,
    input  logic [SCAN_W-1:0]      last_pos,
    input  logic [GR_WIDTH-1:0]    init_gr,
    input  logic                   abort,
    rdoq_scan_sequencer_if.master  bus,
    output logic                   busy,
    output logic                   cg_done,
    output logic                   blk_done,
    output logic [SCAN_W:0]        nz_count,
    output logic                   err
);
    import rdoq_pkg::*;

    localparam int unsigned WD_W = $clog2(DONE_TIMEOUT + 1);

    seq_state_t          state;
    logic [SCAN_W-1:0]   pos;
    logic [GR_WIDTH-1:0] gr;
    logic [LVL_W-1:0]    level_q;
    logic                cg_bnd_q;
    logic                cg_first;
    logic                wd_expired;

    assign cg_first = (pos[CG_LOG2-1:0] == '0) && (pos != '0);

    // Loaded with DONE_TIMEOUT-1 so that done is still honoured in the
    // DONE_TIMEOUT-th WAIT cycle, the one in which the counter reads zero.
    rdoq_done_watchdog #(
        .CNT_W (WD_W)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_UPD),
        .en       (state == ST_WAIT),
        .load_val (WD_W'(DONE_TIMEOUT - 1)),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pos      <= '0;
            gr       <= '0;
            level_q  <= '0;
            cg_bnd_q <= 1'b0;
            nz_count <= '0;
            err      <= 1'b0;
            cg_done  <= 1'b0;
            blk_done <= 1'b0;
        end else begin
            cg_done  <= 1'b0;
            blk_done <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (blk_start) begin
                            pos      <= last_pos;
                            gr       <= init_gr;
                            nz_count <= '0;
                            err      <= 1'b0;
                            state    <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (bus.lvl_valid) begin
                            level_q  <= bus.lvl_value;
                            cg_bnd_q <= cg_first;
                            if (bus.lvl_value != '0) begin
                                nz_count <= nz_count + 1'b1;
                            end
                            state <= ST_UPD;
                        end
                    end
                    ST_UPD: begin
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (bus.csm_done) begin
                            if (pos == '0) begin
                                blk_done <= 1'b1;
                                state    <= ST_IDLE;
                            end else begin
                                cg_done <= cg_bnd_q;
                                pos     <= pos - 1'b1;
                                state   <= ST_REQ;
                            end
                        end else if (wd_expired) begin
                            err   <= 1'b1;
                            state <= ST_ERR;
                        end
                    end
                    ST_ERR: begin
                        state <= ST_ERR;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy                = (state != ST_IDLE);
    assign bus.lvl_req         = (state == ST_REQ);
    assign bus.lvl_pos         = pos;
    assign bus.csm_start       = (state == ST_UPD);
    assign bus.csm_level       = level_q;
    assign bus.csm_scan_pos    = CSM_POS_W'(pos);
    assign bus.csm_cg_boundary = cg_bnd_q;
    assign bus.csm_init_gr     = gr;

endmodule

// File: tb/tb_rdoq_scan_sequencer.sv
// Scoreboard bench for rdoq_scan_sequencer: expected context-manager updates are
// queued by the stimulus and checked by an independent monitor.
module tb_rdoq_scan_sequencer;
    import rdoq_pkg::*;

    localparam int SW = 10;
    localparam int GW = 3;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          blk_start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] last_pos = '0;
    logic [GW-1:0] init_gr = '0;
    logic          busy, cg_done, blk_done, err;
    logic [SW:0]   nz_count;

    rdoq_scan_sequencer_if #(.SCAN_W(SW), .GR_WIDTH(GW), .LVL_W(LW)) bus ();

    rdoq_scan_sequencer #(
        .SCAN_W(SW), .CG_LOG2(4), .GR_WIDTH(GW), .LVL_W(LW), .DONE_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .blk_start(blk_start), .last_pos(last_pos),
        .init_gr(init_gr), .abort(abort), .bus(bus), .busy(busy),
        .cg_done(cg_done), .blk_done(blk_done), .nz_count(nz_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LW-1:0] level;
        logic [15:0]   pos;
        logic          bnd;
        logic [GW-1:0] gr;
    } exp_t;

    exp_t    exp_q[$];
    int      compared = 0;
    int      mismatched = 0;
    int      cyc = 0;
    int      cg_cnt = 0;
    int      blk_cnt = 0;
    int      req3_cnt = 0;
    logic [LW-1:0] lvl_tab [1024];
    int      delay_tab [1024];
    bit      withhold = 1'b0;
    logic    pend = 1'b0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_block(input int last, input int stop, input logic [GW-1:0] gr);
        exp_t e;
        for (int p = last; p >= stop; p--) begin
            e.level = lvl_tab[p];
            e.pos   = 16'(p);
            e.bnd   = ((p % 16) == 0) && (p != 0);
            e.gr    = gr;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_block(input int last, input logic [GW-1:0] gr);
        @(negedge clk);
        blk_start = 1'b1;
        last_pos  = SW'(last);
        init_gr   = gr;
        @(negedge clk);
        blk_start = 1'b0;
    endtask

    task automatic wait_blk_done(input string name, input int budget, output int t_done);
        bit found;
        found  = 1'b0;
        t_done = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (blk_done) begin
                found  = 1'b1;
                t_done = cyc;
                break;
            end
        end
        cmp({name, "_blk_done_seen"}, 64'(found), 64'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Level selector model: answers after delay_tab[pos] request cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.lvl_valid = 1'b0;
        bus.lvl_value = '0;
        forever begin
            @(negedge clk);
            if (bus.lvl_req) begin
                if (wcnt >= delay_tab[int'(bus.lvl_pos)]) begin
                    bus.lvl_valid = 1'b1;
                    bus.lvl_value = lvl_tab[int'(bus.lvl_pos)];
                    wcnt = 0;
                end else begin
                    bus.lvl_valid = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.lvl_valid = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Context manager model: done one cycle after start unless withheld.
    initial begin
        bus.csm_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.csm_done = pend && !withhold;
            pend = bus.csm_start;
        end
    end

    // Monitor: pops the scoreboard on every csm_start and tallies pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.csm_start) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL csm_start_unexpected: got pos %0d expected no update", bus.csm_scan_pos);
                    end else begin
                        e = exp_q.pop_front();
                        cmp("csm_level", 64'(bus.csm_level), 64'(e.level));
                        cmp("csm_scan_pos", 64'(bus.csm_scan_pos), 64'(e.pos));
                        cmp("csm_cg_boundary", 64'(bus.csm_cg_boundary), 64'(e.bnd));
                        cmp("csm_init_gr", 64'(bus.csm_init_gr), 64'(e.gr));
                    end
                end
                if (cg_done) cg_cnt++;
                if (blk_done) blk_cnt++;
                if (bus.lvl_req && (bus.lvl_pos == 10'd3)) req3_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int t_req, t_done, cg0, blk0, ok;
        for (int i = 0; i < 1024; i++) begin
            lvl_tab[i]   = 16'd1;
            delay_tab[i] = 0;
        end

        // Reset state
        #3;
        cmp("rst_busy", 64'(busy), 64'd0);
        cmp("rst_lvl_req", 64'(bus.lvl_req), 64'd0);
        cmp("rst_csm_start", 64'(bus.csm_start), 64'd0);
        cmp("rst_err", 64'(err), 64'd0);
        cmp("rst_nz_count", 64'(nz_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 17..0, all levels 1
        cg0 = cg_cnt;
        push_block(17, 0, 3'd1);
        start_block(17, 3'd1);
        t_req = cyc;
        cmp("t1_lvl_req", 64'(bus.lvl_req), 64'd1);
        cmp("t1_lvl_pos", 64'(bus.lvl_pos), 64'd17);
        cmp("t1_busy", 64'(busy), 64'd1);
        wait_blk_done("t1", 200, t_done);
        cmp("t1_latency", 64'(t_done - t_req), 64'd54);
        cmp("t1_nz_count", 64'(nz_count), 64'd18);
        @(negedge clk);
        cmp("t1_busy_after", 64'(busy), 64'd0);
        cmp("t1_cg_done_cnt", 64'(cg_cnt - cg0), 64'd1);
        cmp("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // 2: last_pos 0, level 0
        lvl_tab[0] = 16'd0;
        cg0 = cg_cnt;
        push_block(0, 0, 3'd2);
        start_block(0, 3'd2);
        wait_blk_done("t2", 20, t_done);
        cmp("t2_nz_count", 64'(nz_count), 64'd0);
        @(negedge clk);
        cmp("t2_cg_done_cnt", 64'(cg_cnt - cg0), 64'd0);
        cmp("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // 3: level selector stalls 5 cycles at pos 3
        lvl_tab[5] = 16'd3; lvl_tab[4] = 16'd0; lvl_tab[3] = 16'd7;
        lvl_tab[2] = 16'd1; lvl_tab[1] = 16'd0; lvl_tab[0] = 16'd2;
        delay_tab[3] = 5;
        req3_cnt = 0;
        push_block(5, 0, 3'd4);
        start_block(5, 3'd4);
        wait_blk_done("t3", 100, t_done);
        cmp("t3_req_pos3_cycles", 64'(req3_cnt), 64'd6);
        cmp("t3_nz_count", 64'(nz_count), 64'd4);
        @(negedge clk);
        cmp("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        delay_tab[3] = 0;

        // 4: csm_done withheld -> timeout, ERR, abort, restart clears err
        withhold = 1'b1;
        push_block(2, 2, 3'd0);
        start_block(2, 3'd0);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.csm_start) begin ok = 1; break; end
            @(negedge clk);
        end
        cmp("t4_csm_start_seen", 64'(ok), 64'd1);
        repeat (4) @(negedge clk);
        cmp("t4_err_before_timeout", 64'(err), 64'd0);
        @(negedge clk);
        cmp("t4_err_at_timeout", 64'(err), 64'd1);
        cmp("t4_busy_in_err", 64'(busy), 64'd1);
        withhold = 1'b0;
        repeat (5) @(negedge clk);
        cmp("t4_busy_still", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cmp("t4_busy_after_abort", 64'(busy), 64'd0);
        cmp("t4_err_kept", 64'(err), 64'd1);
        cmp("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        lvl_tab[0] = 16'd5;
        push_block(0, 0, 3'd3);
        start_block(0, 3'd3);
        cmp("t4_err_cleared", 64'(err), 64'd0);
        wait_blk_done("t4", 20, t_done);
        cmp("t4_nz_count", 64'(nz_count), 64'd1);

        // 5: abort while requesting pos 9 of a 31..0 block
        for (int i = 0; i < 32; i++) lvl_tab[i] = 16'd1;
        delay_tab[9] = 3;
        push_block(31, 10, 3'd5);
        start_block(31, 3'd5);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.lvl_req && (bus.lvl_pos == 10'd9)) begin ok = 1; break; end
        end
        cmp("t5_reached_pos9", 64'(ok), 64'd1);
        blk0 = blk_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cmp("t5_lvl_req_dropped", 64'(bus.lvl_req), 64'd0);
        cmp("t5_busy", 64'(busy), 64'd0);
        cmp("t5_nz_partial", 64'(nz_count), 64'd22);
        repeat (3) @(negedge clk);
        cmp("t5_no_blk_done", 64'(blk_cnt - blk0), 64'd0);
        cmp("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        delay_tab[9] = 0;
        push_block(31, 0, 3'd5);
        start_block(31, 3'd5);
        cmp("t5_restart_pos", 64'(bus.lvl_pos), 64'd31);
        wait_blk_done("t5", 200, t_done);
        cmp("t5_nz_full", 64'(nz_count), 64'd32);

        // 6: blk_start while busy is ignored; then async reset mid-block
        lvl_tab[4] = 16'd1; lvl_tab[3] = 16'd0; lvl_tab[2] = 16'd1;
        lvl_tab[1] = 16'd0; lvl_tab[0] = 16'd1;
        push_block(4, 0, 3'd2);
        start_block(4, 3'd2);
        repeat (2) @(negedge clk);
        blk_start = 1'b1; last_pos = 10'd20; init_gr = 3'd7;
        @(negedge clk);
        blk_start = 1'b0;
        wait_blk_done("t6", 50, t_done);
        cmp("t6_nz_count", 64'(nz_count), 64'd3);
        @(negedge clk);
        cmp("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < 11; i++) lvl_tab[i] = 16'd2;
        push_block(10, 0, 3'd6);
        start_block(10, 3'd6);
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("t6_rst_busy", 64'(busy), 64'd0);
        cmp("t6_rst_lvl_req", 64'(bus.lvl_req), 64'd0);
        cmp("t6_rst_lvl_pos", 64'(bus.lvl_pos), 64'd0);
        cmp("t6_rst_csm_start", 64'(bus.csm_start), 64'd0);
        cmp("t6_rst_csm_level", 64'(bus.csm_level), 64'd0);
        cmp("t6_rst_nz_count", 64'(nz_count), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        cmp("t6_idle_after_reset", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
